// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter that drains a registered-output byte FIFO.
// A byte tagged last is followed by a stop-bit frame_done pulse and an idle gap.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_dout_last,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_wr_en,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int GAP_MUL = (GAP_BITS > 0) ? GAP_BITS : 1;
    localparam int CNT_MAX = CLKS_PER_BIT * GAP_MUL;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CNT_MAX - 1);
    localparam logic          HAS_GAP  = (GAP_BITS > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            last_q, last_d;
    logic            tx_q, tx_d;
    logic            bit_end;
    logic            accept;

    // The FIFO lets a landing write win over a read, so a pop is only real
    // when no write is being accepted in the same cycle.
    assign fifo_rd_en = rst_n && (state_q == S_IDLE) && !fifo_empty;
    assign accept     = fifo_rd_en && !(fifo_wr_en && !fifo_full);
    assign bit_end    = (cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        last_d    = last_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = S_FETCH;
            end
            S_FETCH: begin
                shreg_d = fifo_dout;
                last_d  = fifo_dout_last;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = (last_q && HAS_GAP) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx edges line up with state entry.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            last_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            tx_q      <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && bit_end && last_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: behavioural FIFO, waveform-queue model checked
// every cycle, a line receiver, and directed literal checks per scenario.
module tb_uart_tx_fifo_drain;

    localparam int CPB   = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_dout_last = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_full = 1'b0;
    logic       fifo_wr_en = 1'b0;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [8:0] wr_data = 9'd0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_dout      (fifo_dout),
        .fifo_dout_last (fifo_dout_last),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_rd_en     (fifo_rd_en),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    // Byte FIFO with registered read data and write-over-read priority.
    logic [8:0] fq[$];
    logic [8:0] popped;
    always @(posedge clk) begin
        if (fifo_wr_en && !fifo_full) begin
            fq.push_back(wr_data);
        end else if (fifo_rd_en && !fifo_empty) begin
            popped = fq.pop_front();
            fifo_dout      <= popped[7:0];
            fifo_dout_last <= popped[8];
        end
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() == DEPTH);
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Expected output waveform, one entry {tx, busy, frame_done} per cycle.
    logic [2:0] eq[$];

    task automatic add_frame(input logic [8:0] b);
        logic bitv;
        logic fdv;
        eq.push_back(3'b110);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CPB; c++) begin
                bitv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                fdv  = (k == 9) && (c == CPB - 1) && b[8];
                eq.push_back({bitv, 1'b1, fdv});
            end
        end
        if (b[8]) begin
            for (int c = 0; c < GAP * CPB; c++) eq.push_back(3'b110);
        end
    endtask

    int busy_cnt, fd_cnt, rd_cnt, tx0_cnt;
    int fd_cycs[$];
    int acc_cycs[$];
    int rx_starts[$];
    logic [8:0] rx_bytes[$];
    int rx_pos = -1;
    logic [9:0] rx_bits;

    logic [2:0] m_e;
    logic       m_rd;
    logic       m_acc;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            eq.delete();
            rx_pos = -1;
            if (mon_en) begin
                chk1("rst_tx", tx, 1'b1);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_rd_en", fifo_rd_en, 1'b0);
                chk1("rst_frame_done", frame_done, 1'b0);
            end
        end else if (mon_en) begin
            if (eq.size() > 0) begin
                m_e   = eq.pop_front();
                m_rd  = 1'b0;
                m_acc = 1'b0;
            end else begin
                m_e   = 3'b100;
                m_rd  = (fq.size() != 0);
                m_acc = m_rd && !(fifo_wr_en && !fifo_full);
            end
            chk1("tx", tx, m_e[2]);
            chk1("busy", busy, m_e[1]);
            chk1("frame_done", frame_done, m_e[0]);
            chk1("rd_en", fifo_rd_en, m_rd);
            if (m_acc) begin
                acc_cycs.push_back(cyc);
                add_frame(fq[0]);
            end
            busy_cnt += int'(busy);
            rd_cnt   += int'(fifo_rd_en);
            tx0_cnt  += int'(!tx);
            if (frame_done) begin
                fd_cnt++;
                fd_cycs.push_back(cyc);
            end
            // Line receiver: samples each bit one cycle into its bit period.
            if (rx_pos < 0 && tx === 1'b0) begin
                rx_pos = 0;
                rx_starts.push_back(cyc);
            end
            if (rx_pos >= 0) begin
                if (rx_pos % CPB == 1) rx_bits[rx_pos / CPB] = tx;
                if (rx_pos == 10 * CPB - 1) begin
                    rx_bytes.push_back({rx_bits[9], rx_bits[8:1]});
                    rx_pos = -1;
                end else begin
                    rx_pos++;
                end
            end
        end
    end

    function automatic int rxb(input int i);
        return (i < rx_bytes.size()) ? int'(rx_bytes[i]) : -1;
    endfunction
    function automatic int rxs(input int i);
        return (i < rx_starts.size()) ? rx_starts[i] : -1;
    endfunction
    function automatic int fdc(input int i);
        return (i < fd_cycs.size()) ? fd_cycs[i] : -1;
    endfunction
    function automatic int accc(input int i);
        return (i < acc_cycs.size()) ? acc_cycs[i] : -1;
    endfunction

    task automatic clr();
        busy_cnt = 0; fd_cnt = 0; rd_cnt = 0; tx0_cnt = 0;
        fd_cycs.delete(); acc_cycs.delete();
        rx_starts.delete(); rx_bytes.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        fifo_wr_en = 1'b1;
        wr_data    = {l, d};
        idle(1);
        fifo_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        rst_n = 1'b0;
        idle(1);

        // Reset with a byte already waiting: the pop request must stay low.
        push(8'hA5, 1'b0);
        chk1("reset_tx", tx, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_frame_done", frame_done, 1'b0);
        chk1("reset_rd_en_nonempty", fifo_rd_en, 1'b0);

        // 1: single byte 0xA5, last=0.
        clr();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(60);
        chki("t1_accepts", acc_cycs.size(), 1);
        chki("t1_rd_pulses", rd_cnt, 1);
        chki("t1_byte", rxb(0), 'h1A5);
        chki("t1_latency", rxs(0) - accc(0), 2);
        chki("t1_busy_cycles", busy_cnt, 41);
        chki("t1_frame_done", fd_cnt, 0);

        // 2: 0x3C with last=1, then an 8-cycle gap.
        clr();
        push(8'h3C, 1'b1);
        idle(70);
        chki("t2_byte", rxb(0), 'h13C);
        chki("t2_frame_done", fd_cnt, 1);
        chki("t2_fd_pos", fdc(0) - rxs(0), 39);
        chki("t2_busy_cycles", busy_cnt, 49);

        // 3: a write lands in the rd_en cycle; the pop retries and nothing is lost.
        clr();
        push(8'h5A, 1'b0);
        push(8'h77, 1'b0);
        idle(100);
        chki("t3_rd_cycles", rd_cnt, 3);
        chki("t3_accepts", acc_cycs.size(), 2);
        chki("t3_byte0", rxb(0), 'h15A);
        chki("t3_byte1", rxb(1), 'h177);
        chki("t3_busy_cycles", busy_cnt, 82);

        // 4: FIFO empty for 100 cycles.
        clr();
        idle(100);
        chki("t4_busy_cycles", busy_cnt, 0);
        chki("t4_rd_cycles", rd_cnt, 0);
        chki("t4_tx_low_cycles", tx0_cnt, 0);

        // 5: reset during data bit 3; the next byte goes out from its start bit.
        clr();
        push(8'h96, 1'b0);
        push(8'h42, 1'b1);
        n = 0;
        while (rx_starts.size() == 0 && n < 200) begin idle(1); n++; end
        chki("t5_start_seen", int'(rx_starts.size() > 0), 1);
        s = rxs(0);
        n = 0;
        while (cyc < s + 17 && n < 200) begin idle(1); n++; end
        chki("t5_reached_bit3", int'(cyc >= s + 17), 1);
        #2 rst_n = 1'b0;
        #1;
        chk1("t5_tx_in_reset", tx, 1'b1);
        chk1("t5_busy_in_reset", busy, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(70);
        chki("t5_bytes", rx_bytes.size(), 1);
        chki("t5_byte", rxb(0), 'h142);
        chki("t5_frame_done", fd_cnt, 1);

        // 6: three queued bytes, last on the third.
        clr();
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b1);
        idle(150);
        chki("t6_bytes", rx_bytes.size(), 3);
        chki("t6_byte0", rxb(0), 'h101);
        chki("t6_byte1", rxb(1), 'h102);
        chki("t6_byte2", rxb(2), 'h103);
        chki("t6_spacing01", rxs(1) - rxs(0), 42);
        chki("t6_spacing12", rxs(2) - rxs(1), 42);
        chki("t6_frame_done", fd_cnt, 1);
        chki("t6_fd_pos", fdc(0) - rxs(2), 39);
        chki("t6_busy_cycles", busy_cnt, 131);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
